// File: rtl/division_arbiter.sv
`timescale 1ns/1ps
// division_arbiter
//
// Shares one iterative division core among n_requesters clients. Requests
// are granted round-robin. The winner's operands are latched and sent to the
// core with a one-cycle start pulse, and the result goes back to that client
// with status flags. A zero denominator is answered directly without
// starting the core. A core that never completes is cut off after
// timeout_cycles.
//
// Handshake: a client raises req_valid[i] with its operands and holds them
// until it sees req_ready[i]. A transfer happens on the rising edge where
// both are high. req_ready is only driven in IDLE, is one-hot, and may be
// seen by a client whose req_valid is already high. A client may drop
// req_valid before that edge, and its request is then forgotten. rsp_valid[i]
// is a one-cycle pulse with no back-pressure.
//
// Ports
//   aclk, resetn            clock; asynchronous active-low reset
//   req_valid/req_ready     per-client request handshake
//   req_numerator/denom     packed operands, client i at [i*inout_width +: inout_width]
//   rsp_valid               one-hot result pulse to the owning client
//   rsp_quotient/remainder  result, held until the next response
//   rsp_error_div0          denominator was zero (or the core flagged it)
//   rsp_timeout             core did not complete in time
//   div_*                   connection to the shared division core
//   busy                    arbiter is not idle
//   state_dbg               current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESPOND=3)
module division_arbiter #(
  parameter int inout_width    = 12,
  parameter int n_requesters   = 4,
  parameter int timeout_cycles = 64
) (
  input  logic                                 aclk,
  input  logic                                 resetn,
  input  logic [n_requesters-1:0]              req_valid,
  output logic [n_requesters-1:0]              req_ready,
  input  logic [n_requesters*inout_width-1:0]  req_numerator,
  input  logic [n_requesters*inout_width-1:0]  req_denominator,
  output logic [n_requesters-1:0]              rsp_valid,
  output logic [inout_width-1:0]               rsp_quotient,
  output logic [inout_width-1:0]               rsp_remainder,
  output logic                                 rsp_error_div0,
  output logic                                 rsp_timeout,
  output logic [inout_width-1:0]               div_numerator,
  output logic [inout_width-1:0]               div_denominator,
  output logic                                 div_data_valid,
  input  logic [inout_width-1:0]               div_quotient,
  input  logic [inout_width-1:0]               div_remainder,
  input  logic                                 div_data_ready,
  input  logic                                 div_error_div0,
  output logic                                 busy,
  output logic [1:0]                           state_dbg
);

  localparam int PW = $clog2(n_requesters);
  localparam int TW = $clog2(timeout_cycles);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          grant;
  logic [PW-1:0]          winner;
  logic                   found;
  int                     idx;
  logic [TW-1:0]          tcnt;
  logic                   dr_prev;
  logic                   completion;
  logic                   timed_out;
  logic [inout_width-1:0] num_sel;
  logic [inout_width-1:0] den_sel;

  // Round-robin search. The loop runs from the farthest candidate back to
  // rr_ptr, so the candidate closest to rr_ptr is the last one written and
  // therefore wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = n_requesters - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= n_requesters) idx = idx - n_requesters;
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign num_sel = req_numerator[winner*inout_width +: inout_width];
  assign den_sel = req_denominator[winner*inout_width +: inout_width];

  // Completion is a rising edge of div_data_ready. A level left high by an
  // earlier (possibly aborted) operation must not finish a new one.
  assign completion = (state == WAIT) && div_data_ready && !dr_prev;
  assign timed_out  = (state == WAIT) && !completion &&
                      (tcnt == TW'(timeout_cycles - 1));

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    div_data_valid = 1'b0;
    rsp_valid      = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          state_nxt         = (den_sel == '0) ? RESPOND : ISSUE;
        end
      end
      ISSUE: begin
        div_data_valid = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        if (completion || timed_out) state_nxt = RESPOND;
      end
      RESPOND: begin
        rsp_valid[grant] = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr          <= '0;
      grant           <= '0;
      tcnt            <= '0;
      dr_prev         <= 1'b0;
      div_numerator   <= '0;
      div_denominator <= '0;
      rsp_quotient    <= '0;
      rsp_remainder   <= '0;
      rsp_error_div0  <= 1'b0;
      rsp_timeout     <= 1'b0;
    end else begin
      dr_prev <= div_data_ready;
      case (state)
        IDLE: begin
          if (found) begin
            grant           <= winner;
            div_numerator   <= num_sel;
            div_denominator <= den_sel;
            // Division by zero is answered here, the core is never started.
            if (den_sel == '0) begin
              rsp_quotient   <= '0;
              rsp_remainder  <= '0;
              rsp_error_div0 <= 1'b1;
              rsp_timeout    <= 1'b0;
            end
          end
        end
        ISSUE: begin
          tcnt <= '0;
        end
        WAIT: begin
          if (completion) begin
            rsp_quotient   <= div_quotient;
            rsp_remainder  <= div_remainder;
            rsp_error_div0 <= div_error_div0;
            rsp_timeout    <= 1'b0;
          end else if (timed_out) begin
            rsp_quotient   <= '0;
            rsp_remainder  <= '0;
            rsp_error_div0 <= 1'b0;
            rsp_timeout    <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESPOND: begin
          rr_ptr <= (grant == PW'(n_requesters - 1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
